// File: rtl/gate_bist_checker.sv
// Built-in self test for a two-input gate bank. Applies the four input
// vectors 00, 01, 10, 11 in turn, waits SETTLE_CYCLES after each one, then
// compares all seven gate responses against their ideal values. Records a
// per-vector failure bitmap and a count of failing vectors.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | vector applied, counting down the settle time
// CHECK  | sampling and comparing the gate responses
// DONE   | one-cycle end-of-run pulse, pass registered
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       out_and,
  input  logic       out_or,
  input  logic       out_not,
  input  logic       out_nand,
  input  logic       out_nor,
  input  logic       out_xor,
  input  logic       out_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(SETTLE_CYCLES);
  // With no settle time, each vector goes straight to its compare cycle.
  localparam logic [1:0] ST_AFTER_LOAD = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

  logic [1:0] state;
  logic [1:0] idx;
  logic [3:0] wait_cnt;
  logic [6:0] golden;
  logic [6:0] actual;
  logic       mismatch;

  // Ideal gate responses for the vector currently driven, and the observed ones.
  always_comb begin
    golden   = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    actual   = {out_and, out_or, out_not, out_nand, out_nor, out_xor, out_xnor};
    mismatch = |(golden ^ actual);
  end

  // Busy spans the whole run, including the DONE cycle.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Sequencer: vector stepping, settle countdown and result recording.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      wait_cnt  <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= 4'd0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a         <= 1'b0;
            b         <= 1'b0;
            idx       <= 2'd0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            wait_cnt  <= WAIT_INIT;
            state     <= ST_AFTER_LOAD;
          end
        end
        ST_SETTLE: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // One count per failing vector, however many gates disagree.
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            err_count     <= err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            state <= ST_DONE;
            done  <= 1'b1;
            // Fold in the final vector's result, which is not yet in err_count.
            pass  <= (err_count == 3'd0) && !mismatch;
          end else begin
            idx      <= idx + 2'd1;
            {a, b}   <= idx + 2'd1;
            wait_cnt <= WAIT_INIT;
            state    <= ST_AFTER_LOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: a behavioural gate bank with injectable
// faults, a scoreboard of expected run results checked on each done pulse,
// and a second instance with zero settle time.
module tb_gate_bist_checker;

  typedef struct {
    logic       pass;
    logic [3:0] fv;
    logic [2:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, start2;
  logic a, b, a2, b2;
  logic g_and, g_or, g_not, g_nand, g_nor, g_xor, g_xnor;
  logic h_and, h_or, h_not, h_nand, h_nor, h_xor, h_xnor;
  logic busy, done, pass, busy2, done2, pass2;
  logic [3:0] fail_vec, fail_vec2;
  logic [2:0] err_count, err_count2;
  int fault;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gate_bist_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .out_and(g_and), .out_or(g_or), .out_not(g_not), .out_nand(g_nand),
    .out_nor(g_nor), .out_xor(g_xor), .out_xnor(g_xnor),
    .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec), .err_count(err_count)
  );

  gate_bist_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .out_and(h_and), .out_or(h_or), .out_not(h_not), .out_nand(h_nand),
    .out_nor(h_nor), .out_xor(h_xor), .out_xnor(h_xnor),
    .busy(busy2), .done(done2), .pass(pass2), .fail_vec(fail_vec2), .err_count(err_count2)
  );

  // Gate bank under test, with selectable faults.
  always_comb begin
    g_and  = a & b;
    g_or   = a | b;
    g_not  = ~a;
    g_nand = ~(a & b);
    g_nor  = ~(a | b);
    g_xor  = a ^ b;
    g_xnor = ~(a ^ b);
    case (fault)
      1: g_xor = 1'b0;
      2: g_not = a;
      3: begin g_not = a; g_nand = a & b; end
      default: ;
    endcase
  end

  always_comb begin
    h_and  = a2 & b2;
    h_or   = a2 | b2;
    h_not  = ~a2;
    h_nand = ~(a2 & b2);
    h_nor  = ~(a2 | b2);
    h_xor  = a2 ^ b2;
    h_xnor = ~(a2 ^ b2);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    else busy_cnt = 0;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pass", int'(pass), int'(e.pass));
        chk("fail_vec", int'(fail_vec), int'(e.fv));
        chk("err_count", int'(err_count), int'(e.ec));
        chk("done_latency", busy_cnt, 13);
      end
    end
  end

  task automatic push(input logic p, input logic [3:0] fv, input logic [2:0] ec);
    exp_t e;
    e.pass = p;
    e.fv   = fv;
    e.ec   = ec;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ab"}, int'({a, b}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");

    // Correct bank, then results and vector must hold.
    push(1'b1, 4'b0000, 3'd0);
    pulse_start();
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("hold_ab", int'({a, b}), 3);
    chk("hold_pass", int'(pass), 1);
    chk("hold_busy", int'(busy), 0);

    // Fault patterns.
    fault = 1; push(1'b0, 4'b0110, 3'd2); pulse_start(); wait_done(2);
    fault = 2; push(1'b0, 4'b1111, 3'd4); pulse_start(); wait_done(3);
    fault = 3; push(1'b0, 4'b1111, 3'd4); pulse_start(); wait_done(4);
    @(negedge clk);
    chk("hold_err_count", int'(err_count), 4);

    // Reset during the third vector: no done, everything cleared.
    fault = 0;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("third_vector_ab", int'({a, b}), 2);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_idle_zero("midrun_reset");
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", done_cnt, 4);
    push(1'b1, 4'b0000, 3'd0); pulse_start(); wait_done(5);

    // Start pulsed again while busy is ignored.
    push(1'b1, 4'b0000, 3'd0);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(6);
    repeat (20) @(negedge clk);
    chk("single_done", done_cnt, 6);

    // Start held high: back-to-back runs with one IDLE cycle between.
    push(1'b1, 4'b0000, 3'd0);
    push(1'b1, 4'b0000, 3'd0);
    @(negedge clk) start = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_done", int'(done), 1);
    @(negedge clk);
    chk("held_idle_gap", int'(busy), 0);
    @(negedge clk);
    chk("held_restart", int'(busy), 1);
    start = 1'b0;
    wait_done(8);

    // Zero settle time: one cycle per vector, done in the fifth cycle.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("s0_busy", int'(busy2), 1);
    chk("s0_ab0", int'({a2, b2}), 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("s0_ab_step", int'({a2, b2}), i);
    end
    chk("s0_done_early", int'(done2), 0);
    @(negedge clk);
    chk("s0_done", int'(done2), 1);
    chk("s0_pass", int'(pass2), 1);
    chk("s0_fail_vec", int'(fail_vec2), 0);
    chk("s0_err_count", int'(err_count2), 0);
    @(negedge clk);
    chk("s0_idle", int'(busy2), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
